// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one ripple-carry adder between NUM_REQ requesters,
// with a single-entry result slot. Define ADDER_SCHED_SUB_EN to add per-requester subtract.

module adder_rr_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_rr_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
`ifdef ADDER_SCHED_SUB_EN
    input  logic [NUM_REQ-1:0]            req_sub,
`endif
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH:0]           rsp_sum,
    output logic [ID_W-1:0]               rsp_id
);
    typedef enum logic {EMPTY, FULL} state_t;

    typedef struct packed {
        logic [DATA_WIDTH:0] sum;
        logic [ID_W-1:0]     id;
    } slot_t;

    state_t                state, state_d;
    slot_t                 slot;
    logic [ID_W-1:0]       ptr, ptr_nxt;
    logic                  can_issue;
    logic                  grant_any;
    logic                  grant;
    logic [ID_W-1:0]       grant_id;
    logic [DATA_WIDTH-1:0] a_sel, b_sel, b_eff, s_bits;
    logic [DATA_WIDTH:0]   carry;
    logic                  sub_sel;
    logic [DATA_WIDTH:0]   sum_w;

    assign can_issue = (state == EMPTY) || rsp_ready;

    // Scan from farthest to nearest so the candidate closest to ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(ptr) + k) % NUM_REQ]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    assign grant = grant_any && can_issue && !reset;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[grant_id] = 1'b1;
    end

    assign ptr_nxt = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;

    assign a_sel = req_a[grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign b_sel = req_b[grant_id*DATA_WIDTH +: DATA_WIDTH];

`ifdef ADDER_SCHED_SUB_EN
    assign sub_sel = req_sub[grant_id];
`else
    assign sub_sel = 1'b0;
`endif

    // Subtract reuses the adder: a + ~b with carry-in 1; carry-out 1 means no borrow.
    assign b_eff    = sub_sel ? ~b_sel : b_sel;
    assign carry[0] = sub_sel;

    genvar i;
    generate
        for (i = 0; i < DATA_WIDTH; i++) begin : g_fa
            adder_rr_fa u_fa (
                .a    (a_sel[i]),
                .b    (b_eff[i]),
                .cin  (carry[i]),
                .s    (s_bits[i]),
                .cout (carry[i+1])
            );
        end
    endgenerate

    assign sum_w = {carry[DATA_WIDTH], s_bits};

    always_comb begin
        state_d = state;
        case (state)
            EMPTY: if (grant) state_d = FULL;
            FULL: begin
                if (grant)          state_d = FULL;
                else if (rsp_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            ptr   <= '0;
            slot  <= '0;
        end else begin
            state <= state_d;
            if (grant) begin
                slot.sum <= sum_w;
                slot.id  <= grant_id;
                ptr      <= ptr_nxt;
            end
        end
    end

    assign rsp_valid = (state == FULL);
    assign rsp_sum   = slot.sum;
    assign rsp_id    = slot.id;
endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
- Shares one DATA_WIDTH-bit ripple-carry adder datapath between NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- A round-robin arbiter selects one pair per cycle and registers the sum with the winner's ID into a single-entry output slot. The slot has valid/ready backpressure.
- Sits between operand producers and the shared adder resource.

Parameters:
- DATA_WIDTH, 8, operand width; sum is DATA_WIDTH+1 bits.
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), width of requester ID.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- req_valid  input  NUM_REQ  per-requester operand valid
- req_a  input  NUM_REQ*DATA_WIDTH  flattened operand A; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_b  input  NUM_REQ*DATA_WIDTH  flattened operand B, same packing
- req_ready  output  NUM_REQ  one-hot grant; pair i accepted when req_valid[i] && req_ready[i]
- rsp_valid  output  1  result slot occupied
- rsp_ready  input  1  consumer accepts result
- rsp_sum  output  DATA_WIDTH+1  registered a+b, carry-out in MSB
- rsp_id  output  ID_W  index of requester that produced rsp_sum

Behaviour:
- Reset (async, active high):
  - rsp_valid=0, rsp_sum=0, rsp_id=0.
  - Round-robin pointer ptr=0, FSM=EMPTY.
  - req_ready=0 while reset is asserted.
- FSM states:
  - EMPTY: slot free.
  - FULL: rsp_valid=1, holding a result.
- can_issue = (state==EMPTY) || (state==FULL && rsp_ready).
- Arbitration (combinational):
  - When can_issue, grant the first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready is one-hot on the granted index. It is 0 when there is no request or !can_issue.
  - req_ready never asserts for an index whose req_valid is 0.
- On a grant to requester g (rising edge):
  - rsp_sum <= {1'b0,a_g} + {1'b0,b_g} at full DATA_WIDTH+1 width, no truncation.
  - rsp_id <= g; state -> FULL; ptr <= (g+1) mod NUM_REQ.
- Latency: accepted on edge N, result visible (rsp_valid=1) after edge N. Sustained throughput is one result per cycle while rsp_ready=1.
- FULL with rsp_ready=0: rsp_sum, rsp_id and rsp_valid hold stable; all req_ready=0; ptr unchanged.
- FULL with rsp_ready=1 and no request: state -> EMPTY, rsp_valid=0. rsp_sum/rsp_id keep their last value.
- Simultaneous drain and grant: the new result replaces the old one in the same edge and rsp_valid stays 1.
- Requesters not granted must hold req_valid/operands. The block does not latch un-granted operands.
- ptr advances only on a grant. With a single active requester, it is granted every cycle.
- Fairness: with all NUM_REQ requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0,... Each requester is guaranteed service within NUM_REQ grants.
- Reset mid-operation: the slot contents are dropped immediately (rsp_valid=0 asynchronously) and ptr returns to 0.

Optional Feature:
- Macro: ADDER_SCHED_SUB_EN.
- Defined:
  - Adds input req_sub [NUM_REQ-1:0].
  - A granted requester with req_sub[g]=1 computes a_g + ~b_g + 1 at DATA_WIDTH+1 width. The MSB is the carry-out, so MSB=1 means a>=b, i.e. no borrow.
  - req_sub is sampled with the operands on the grant edge.
- Undefined: the port is absent and only addition is performed. All other behaviour is identical.

Test Plan:
- Reset mid-stream: assert reset while rsp_valid=1 -> rsp_valid drops without waiting for a clock edge. After release with all req_valid=0, req_ready=0 and rsp_valid=0.
- Single add, carry: req_valid=4'b0100, a2=8'hFF, b2=8'h01, rsp_ready=1 -> req_ready=4'b0100 that cycle. Next cycle rsp_valid=1, rsp_sum=9'h100, rsp_id=2.
- Round robin: req_valid=4'b1111 held, rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3 and one result per cycle.
- Backpressure: slot FULL with rsp_sum=9'h0AA, rsp_ready=0 for 5 cycles with requests pending -> req_ready=0 and outputs stable. The cycle rsp_ready rises, the next requester after ptr is granted and the result replaces the slot with no bubble.
- Pointer skip/wrap: ptr=3, req_valid=4'b0011 -> grant 0 then 1. ptr ends at 2, then req_valid=4'b1000 -> grant 3.
- ADDER_SCHED_SUB_EN: a1=8'h05, b1=8'h07, req_sub[1]=1 -> rsp_sum=9'h0FE (MSB 0 = borrow). With a1=8'h07, b1=8'h05 -> rsp_sum=9'h102.
